// File: rtl/matrix_ascii_formatter_if.sv
// Element-read and TX byte channels of matrix_ascii_formatter.
// A byte moves on tx_valid && tx_ready at a rising edge; while tx_valid=1 and tx_ready=0, tx_data holds and tx_valid stays high. elem_rd_en is a one-cycle request answered later by a one-cycle elem_rd_valid.
interface matrix_ascii_formatter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              elem_rd_en;
   logic [ADDR_W-1:0] elem_addr;
   logic              elem_rd_valid;
   logic [DATA_W-1:0] elem_rd_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output elem_rd_en, elem_addr, tx_data, tx_valid,
      input  elem_rd_valid, elem_rd_data, tx_ready
   );

   modport slave (
      input  elem_rd_en, elem_addr, tx_data, tx_valid,
      output elem_rd_valid, elem_rd_data, tx_ready
   );
endinterface

// File: rtl/matrix_ascii_formatter.sv
// Streams a matrix as right-aligned decimal ASCII text with optional header.
// Define FMT_SIGNED_EN to treat elements as two's complement.
module matrix_ascii_formatter #(
   parameter int DATA_W  = 8,
   parameter int MAX_DIM = 5,
   parameter int ID_W    = 4,
   parameter int FIELD_W = 3,
   parameter int ADDR_W  = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [ID_W-1:0]        matrix_id,
   input  logic [2:0]             dim_m,
   input  logic [2:0]             dim_n,
   matrix_ascii_formatter_if.master bus,
   output logic                   busy,
   output logic                   format_done,
   output logic                   fmt_err,
   output logic [3:0]             dbg_state_o
);
   localparam logic [3:0] S_IDLE = 4'd0, S_HDR = 4'd1, S_FETCH = 4'd2, S_WAIT = 4'd3,
                          S_CONV = 4'd4, S_PAD = 4'd5, S_SIGN = 4'd6, S_DIGIT = 4'd7,
                          S_SEP = 4'd8, S_TAIL = 4'd9, S_DONE = 4'd10;

   localparam int MAXV = (1 << DATA_W) - 1;
   localparam int NDIG = 1 + int'(MAXV >= 10) + int'(MAXV >= 100) + int'(MAXV >= 1000) + int'(MAXV >= 10000);

   function automatic logic [16:0] pow10(input logic [2:0] k);
      case (k)
         3'd0:    return 17'd1;
         3'd1:    return 17'd10;
         3'd2:    return 17'd100;
         3'd3:    return 17'd1000;
         default: return 17'd10000;
      endcase
   endfunction

   logic [3:0]        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [2:0]        m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d, raddr_q, raddr_d;
   logic [DATA_W-1:0] rem_q, rem_d, mag;
   logic              neg_q, neg_d, is_neg;
   logic [2:0]        pos_q, pos_d, len_q, len_d, fin_len;
   logic [3:0]        dig_q [8];
   logic [3:0]        dig_d [8];
   logic [4:0]        cnt_q, cnt_d;
   logic              rd_en_q, rd_en_d, txv_q, txv_d, busy_q, busy_d;
   logic              done_q, done_d, err_q, err_d;
   logic [7:0]        txd_q, txd_d;

   logic              slot_free, snd, req_err;
   logic [7:0]        snd_b, hdr_b;
   logic [16:0]       pw;
   logic [47:0]       hdr_word;
   logic [3:0]        tens;
   logic [4:0]        idl, hdr_len, hdr_j, hdr_k;
   int                pad_w;

   always_comb begin
      is_neg = 1'b0;
`ifdef FMT_SIGNED_EN
      is_neg = bus.elem_rd_data[DATA_W-1];
`endif
      mag = is_neg ? (~bus.elem_rd_data + 1'b1) : bus.elem_rd_data;
   end

   // Header byte at index cnt_q: word, optional " <id>", then " (MxN):\n".
   always_comb begin
      tens = '0;
      for (int t = 1; t < 10; t++) begin
         if (int'(id_q) >= t * 10) tens = 4'(t);
      end
      idl      = (mode_q == 2'd0) ? ((tens != 4'd0) ? 5'd3 : 5'd2) : 5'd0;
      hdr_len  = 5'd14 + idl;
      hdr_j    = cnt_q - 5'd6;
      hdr_k    = cnt_q - 5'd6 - idl;
      hdr_word = (mode_q == 2'd0) ? "Matrix" : "Result";
      hdr_b    = 8'h0A;
      if (cnt_q < 5'd6) begin
         hdr_b = 8'(hdr_word >> (8 * (5 - int'(cnt_q))));
      end else if (cnt_q < 5'd6 + idl) begin
         case (hdr_j)
            5'd0:    hdr_b = 8'h20;
            5'd1:    hdr_b = (tens != 4'd0) ? (8'h30 + {4'h0, tens})
                                            : (8'h30 + 8'(int'(id_q) - 10 * int'(tens)));
            default: hdr_b = 8'h30 + 8'(int'(id_q) - 10 * int'(tens));
         endcase
      end else begin
         case (hdr_k)
            5'd0:    hdr_b = 8'h20;
            5'd1:    hdr_b = 8'h28;
            5'd2:    hdr_b = 8'h30 + {5'h0, m_q};
            5'd3:    hdr_b = 8'h78;
            5'd4:    hdr_b = 8'h30 + {5'h0, n_q};
            5'd5:    hdr_b = 8'h29;
            5'd6:    hdr_b = 8'h3A;
            default: hdr_b = 8'h0A;
         endcase
      end
   end

   assign req_err = (mode == 2'd3) || (dim_m == 3'd0) || (dim_n == 3'd0) ||
                    (int'(dim_m) > MAX_DIM) || (int'(dim_n) > MAX_DIM) ||
                    ((mode == 2'd0) && (int'(matrix_id) > 99));
   assign slot_free = !txv_q || bus.tx_ready;

   always_comb begin
      state_d = state_q; mode_d = mode_q; id_d = id_q; m_d = m_q; n_d = n_q;
      row_d = row_q; col_d = col_q; addr_d = addr_q; raddr_d = raddr_q;
      rem_d = rem_q; neg_d = neg_q; pos_d = pos_q; len_d = len_q; dig_d = dig_q;
      cnt_d = cnt_q; rd_en_d = 1'b0; busy_d = busy_q; done_d = 1'b0; err_d = 1'b0;
      txv_d = txv_q && !bus.tx_ready; txd_d = txd_q;
      snd = 1'b0; snd_b = 8'h00; pw = pow10(pos_q); fin_len = 3'd1; pad_w = 0;
      case (state_q)
         S_IDLE: if (start) begin
            mode_d = mode; id_d = matrix_id; m_d = dim_m; n_d = dim_n;
            row_d = '0; col_d = '0; addr_d = '0; cnt_d = '0; busy_d = 1'b1;
            if (req_err) begin
               state_d = S_DONE; done_d = 1'b1; err_d = 1'b1;
            end else begin
               state_d = (mode == 2'd2) ? S_FETCH : S_HDR;
            end
         end
         S_HDR: if (slot_free) begin
            snd = 1'b1; snd_b = hdr_b;
            if (cnt_q == hdr_len - 5'd1) begin
               cnt_d = '0; state_d = S_FETCH;
            end else cnt_d = cnt_q + 5'd1;
         end
         S_FETCH: begin
            rd_en_d = 1'b1; raddr_d = addr_q; state_d = S_WAIT;
         end
         S_WAIT: if (bus.elem_rd_valid) begin
            rem_d = mag; neg_d = is_neg; pos_d = 3'(NDIG - 1); len_d = '0;
            for (int i = 0; i < 8; i++) dig_d[i] = '0;
            state_d = S_CONV;
         end
         // One subtraction of 10^pos per cycle, most significant position first.
         S_CONV: begin
            if ({{(17-DATA_W){1'b0}}, rem_q} >= pw) begin
               rem_d = rem_q - pw[DATA_W-1:0];
               dig_d[pos_q] = dig_q[pos_q] + 4'd1;
               if (len_q == 3'd0) len_d = pos_q + 3'd1;
            end else if (pos_q == 3'd0) begin
               fin_len = (len_q == 3'd0) ? 3'd1 : len_q;
               len_d   = fin_len;
               pad_w   = FIELD_W - int'(fin_len) - int'(neg_q);
               cnt_d   = (pad_w > 0) ? 5'(pad_w) : 5'd0;
               state_d = S_PAD;
            end else pos_d = pos_q - 3'd1;
         end
         S_PAD: begin
            if (cnt_q != 5'd0) begin
               if (slot_free) begin
                  snd = 1'b1; snd_b = 8'h20; cnt_d = cnt_q - 5'd1;
               end
            end else begin
               cnt_d   = {2'b00, len_q - 3'd1};
               state_d = neg_q ? S_SIGN : S_DIGIT;
            end
         end
         S_SIGN: if (slot_free) begin
            snd = 1'b1; snd_b = 8'h2D; state_d = S_DIGIT;
         end
         S_DIGIT: if (slot_free) begin
            snd = 1'b1; snd_b = 8'h30 + {4'h0, dig_q[cnt_q[2:0]]};
            if (cnt_q == 5'd0) state_d = S_SEP;
            else cnt_d = cnt_q - 5'd1;
         end
         S_SEP: if (slot_free) begin
            snd = 1'b1; addr_d = addr_q + 1'b1; cnt_d = '0; state_d = S_FETCH;
            if (col_q == n_q - 3'd1) begin
               snd_b = 8'h0A; col_d = '0;
               if (row_q == m_q - 3'd1) state_d = S_TAIL;
               else row_d = row_q + 3'd1;
            end else begin
               snd_b = 8'h20; col_d = col_q + 3'd1;
            end
         end
         // cnt_q=1 means the final newline is loaded; finish once it is taken.
         S_TAIL: begin
            if (cnt_q == 5'd0) begin
               if (slot_free) begin
                  snd = 1'b1; snd_b = 8'h0A; cnt_d = 5'd1;
               end
            end else if (bus.tx_ready) begin
               done_d = 1'b1; state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d = 1'b0; state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (snd) begin
         txv_d = 1'b1; txd_d = snd_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE; mode_q <= '0; id_q <= '0; m_q <= '0; n_q <= '0;
         row_q <= '0; col_q <= '0; addr_q <= '0; raddr_q <= '0;
         rem_q <= '0; neg_q <= 1'b0; pos_q <= '0; len_q <= '0; dig_q <= '{default: '0};
         cnt_q <= '0; rd_en_q <= 1'b0; txv_q <= 1'b0; txd_q <= '0;
         busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      end else begin
         state_q <= state_d; mode_q <= mode_d; id_q <= id_d; m_q <= m_d; n_q <= n_d;
         row_q <= row_d; col_q <= col_d; addr_q <= addr_d; raddr_q <= raddr_d;
         rem_q <= rem_d; neg_q <= neg_d; pos_q <= pos_d; len_q <= len_d; dig_q <= dig_d;
         cnt_q <= cnt_d; rd_en_q <= rd_en_d; txv_q <= txv_d; txd_q <= txd_d;
         busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      end
   end

   assign bus.elem_rd_en = rd_en_q;
   assign bus.elem_addr  = raddr_q;
   assign bus.tx_valid   = txv_q;
   assign bus.tx_data    = txd_q;
   assign busy           = busy_q;
   assign format_done    = done_q;
   assign fmt_err        = err_q;
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_matrix_ascii_formatter.sv
// Scoreboard bench for matrix_ascii_formatter with directed matrices.
// Honours FMT_SIGNED_EN when choosing the expected text of the signed case.
module tb_matrix_ascii_formatter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = '0;
   logic [3:0] matrix_id = '0;
   logic [2:0] dim_m = '0, dim_n = '0;
   logic       busy, format_done, fmt_err;
   logic [3:0] dbg_state;

   matrix_ascii_formatter_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   matrix_ascii_formatter dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .matrix_id(matrix_id),
      .dim_m(dim_m), .dim_n(dim_n), .bus(bus), .busy(busy),
      .format_done(format_done), .fmt_err(fmt_err), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   logic [4:0] exp_addr_q[$];
   logic [7:0] mem [0:31];
   int         checks = 0, errors = 0;
   int         tx_cnt = 0, rd_cnt = 0, lat_cnt = 0;
   int         stall_after = 0, stall_left = 0;
   bit         pending = 0, rand_lat = 0, stall_en = 0, stall_done = 0, held = 0;
   logic [4:0] pend_addr = '0;
   logic [7:0] held_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: answers each read after 1 (or random 1..8) cycles.
   initial begin
      bus.elem_rd_valid = 1'b0;
      bus.elem_rd_data  = '0;
      forever begin
         @(negedge clk);
         bus.elem_rd_valid = 1'b0;
         if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               bus.elem_rd_valid = 1'b1;
               bus.elem_rd_data  = mem[pend_addr];
               pending = 0;
            end
         end
         if (bus.elem_rd_en) begin
            rd_cnt++;
            chk("rd_overlap", 32'(pending), 32'd0);
            chk("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("rd_addr", 32'(bus.elem_addr), 32'(exp_addr_q.pop_front()));
            pending   = 1;
            pend_addr = bus.elem_addr;
            lat_cnt   = rand_lat ? int'($urandom_range(1, 8)) : 1;
         end
      end
   end

   // TX monitor: pops the scoreboard on every transfer, checks stall stability.
   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (held) begin
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_data", 32'(bus.tx_data), 32'(held_data));
         end
         if (bus.tx_valid && bus.tx_ready) begin
            tx_cnt++;
            chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
         end
         if (stall_left > 0) begin
            stall_left--;
            bus.tx_ready = 1'b0;
         end else if (stall_en && !stall_done && tx_cnt == stall_after) begin
            stall_done = 1;
            stall_left = 4;
            bus.tx_ready = 1'b0;
         end else begin
            bus.tx_ready = 1'b1;
         end
         held      = bus.tx_valid && !bus.tx_ready;
         held_data = bus.tx_data;
      end
   end

   task automatic queue_case(input string exp_s, input int nel);
      for (int i = 0; i < exp_s.len(); i++) exp_q.push_back(exp_s[i]);
      for (int i = 0; i < nel; i++) exp_addr_q.push_back(5'(i));
      tx_cnt = 0; rd_cnt = 0; stall_done = 0;
   endtask

   task automatic kick(input logic [1:0] md, input logic [3:0] id, input logic [2:0] m, input logic [2:0] n);
      @(negedge clk);
      start = 1'b1; mode = md; matrix_id = id; dim_m = m; dim_n = n;
      @(negedge clk);
      start = 1'b0; mode = 2'd3; matrix_id = '1; dim_m = '0; dim_n = '0;
   endtask

   task automatic run_case(input logic [1:0] md, input logic [3:0] id, input logic [2:0] m,
                           input logic [2:0] n, input string exp_s, input bit exp_err);
      int nel;
      nel = exp_err ? 0 : int'(m) * int'(n);
      queue_case(exp_s, nel);
      kick(md, id, m, n);
      chk("busy_rise", 32'(busy), 32'd1);
      if (exp_err) begin
         chk("err_done_timing", 32'(format_done), 32'd1);
         chk("err_flag", 32'(fmt_err), 32'd1);
      end else begin
         for (int c = 0; c < 4000 && !format_done; c++) @(negedge clk);
         chk("done_seen", 32'(format_done), 32'd1);
         chk("err_flag_clear", 32'(fmt_err), 32'd0);
      end
      chk("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(format_done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      chk("byte_count", 32'(tx_cnt), 32'(exp_s.len()));
      chk("read_count", 32'(rd_cnt), 32'(nel));
      chk("addr_left", 32'(exp_addr_q.size()), 32'd0);
   endtask

   task automatic load_2x2();
      mem[0] = 8'd1; mem[1] = 8'd23; mem[2] = 8'd255; mem[3] = 8'd0;
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_rd_en", 32'(bus.elem_rd_en), 32'd0);
      chk("rst_addr", 32'(bus.elem_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(format_done), 32'd0);
      chk("rst_err", 32'(fmt_err), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      load_2x2();
      run_case(2'd2, 4'd0, 3'd2, 3'd2, "  1  23\n255   0\n\n", 1'b0);

      mem[0] = 8'd7; mem[1] = 8'd8; mem[2] = 8'd9;
      run_case(2'd0, 4'd12, 3'd3, 3'd1, "Matrix 12 (3x1):\n  7\n  8\n  9\n\n", 1'b0);

      mem[0] = 8'd0;
      run_case(2'd0, 4'd5, 3'd1, 3'd1, "Matrix 5 (1x1):\n  0\n\n", 1'b0);

      mem[0] = 8'd9; mem[1] = 8'd10; mem[2] = 8'd99; mem[3] = 8'd100; mem[4] = 8'd5;
      mem[5] = 8'd200; mem[6] = 8'd0; mem[7] = 8'd1; mem[8] = 8'd128;
      run_case(2'd2, 4'd0, 3'd3, 3'd3, "  9  10  99\n100   5 200\n  0   1 128\n\n", 1'b0);

      load_2x2();
      rand_lat = 1; stall_en = 1; stall_after = 3;
      run_case(2'd2, 4'd0, 3'd2, 3'd2, "  1  23\n255   0\n\n", 1'b0);
      rand_lat = 0; stall_en = 0;

      mem[0] = 8'hFB; mem[1] = 8'h80;
`ifdef FMT_SIGNED_EN
      run_case(2'd1, 4'd0, 3'd1, 3'd2, "Result (1x2):\n -5 -128\n\n", 1'b0);
`else
      run_case(2'd1, 4'd0, 3'd1, 3'd2, "Result (1x2):\n251 128\n\n", 1'b0);
`endif

      run_case(2'd2, 4'd0, 3'd2, 3'd0, "", 1'b1);
      run_case(2'd2, 4'd0, 3'd6, 3'd2, "", 1'b1);
      run_case(2'd3, 4'd0, 3'd2, 3'd2, "", 1'b1);

      load_2x2();
      queue_case("  1  23\n255   0\n\n", 4);
      kick(2'd2, 4'd0, 3'd2, 3'd2);
      found = 0;
      for (int c = 0; c < 2000 && !found; c++) begin
         if (rd_cnt >= 2 && dbg_state == 4'd7) found = 1;
         else @(negedge clk);
      end
      chk("rst_reach_digit", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd_en", 32'(bus.elem_rd_en), 32'd0);
      chk("midrst_state", 32'(dbg_state), 32'd0);
      exp_q.delete(); exp_addr_q.delete(); lat_cnt = 0; pending = 0;
      @(negedge clk);
      rst = 1'b0;
      run_case(2'd2, 4'd0, 3'd2, 3'd2, "  1  23\n255   0\n\n", 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
